// File: rtl/top_knightrider.sv
// Knight Rider LED scanner: one lit LED bounces between LSB and MSB,
// one position per tick, with an optional enable prescaler.
module top_knightrider #(
  parameter int N   = 8,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         en,
  output logic [N-1:0] leds
);
  localparam int PW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  logic [PW-1:0] pos, pos_nxt;
  dir_t          dir, dir_nxt;
  logic          tick;

  generate
    if (DIV > 1) begin : g_pre
      localparam int CW = $clog2(DIV);
      logic [CW-1:0] cnt;
      logic          last;

      assign last = (cnt == CW'(DIV - 1));
      assign tick = en && last;

      always_ff @(posedge clk or posedge arst) begin
        if (arst)    cnt <= '0;
        else if (en) cnt <= last ? '0 : cnt + 1'b1;
      end
    end else begin : g_nopre
      assign tick = en;
    end
  endgenerate

  // Endpoints turn around immediately so each end is shown for one step only.
  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    if (tick) begin
      case (dir)
        UP: begin
          if (pos == PW'(N - 1)) begin
            pos_nxt = PW'(N - 2);
            dir_nxt = DOWN;
          end else begin
            pos_nxt = pos + 1'b1;
          end
        end
        DOWN: begin
          if (pos == '0) begin
            pos_nxt = PW'(1);
            dir_nxt = UP;
          end else begin
            pos_nxt = pos - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // leds is registered from pos_nxt so it tracks pos with no extra stage.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pos  <= '0;
      dir  <= UP;
      leds <= {{(N-1){1'b0}}, 1'b1};
    end else begin
      pos  <= pos_nxt;
      dir  <= dir_nxt;
      leds <= {{(N-1){1'b0}}, 1'b1} << pos_nxt;
    end
  end
endmodule

// File: tb/tb_top_knightrider.sv
// Scoreboard bench for top_knightrider: DIV=1 and DIV=3 instances share
// clock and reset; expected LED patterns are queued and checked on negedge.
module tb_top_knightrider;
  logic       clk = 1'b0;
  logic       arst;
  logic       en, en3;
  logic [7:0] leds1, leds3;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q1[$];
  logic [7:0] q3[$];

  top_knightrider #(.N(8), .DIV(1)) u1 (.clk(clk), .arst(arst), .en(en),  .leds(leds1));
  top_knightrider #(.N(8), .DIV(3)) u3 (.clk(clk), .arst(arst), .en(en3), .leds(leds3));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected value per instance per cycle, plus one-hot check.
  always @(negedge clk) begin
    if (q1.size() > 0) begin
      chk("div1_leds", leds1, q1.pop_front());
      chk("div1_onehot", {7'd0, $onehot(leds1)}, 8'd1);
    end
    if (q3.size() > 0) chk("div3_leds", leds3, q3.pop_front());
  end

  // Drive enables, take one edge, then queue the expected patterns.
  task automatic cyc(input logic e1, input logic e3, input logic [7:0] x1, input logic [7:0] x3, input bit c3);
    en  = e1;
    en3 = e3;
    @(posedge clk);
    #1;
    q1.push_back(x1);
    if (c3) q3.push_back(x3);
  endtask

  logic [8:0] va [46] = '{
    9'h102, 9'h104, 9'h108, 9'h110, 9'h120, 9'h140, 9'h180, 9'h140, 9'h120,
    9'h110, 9'h108, 9'h104, 9'h102, 9'h101, 9'h102, 9'h104, 9'h108,
    9'h008, 9'h008, 9'h008, 9'h008, 9'h008,
    9'h110, 9'h120, 9'h140, 9'h180, 9'h140, 9'h120,
    9'h020, 9'h020, 9'h020, 9'h020, 9'h020,
    9'h110, 9'h108, 9'h104, 9'h102, 9'h101, 9'h102, 9'h104, 9'h108,
    9'h110, 9'h120, 9'h140, 9'h180, 9'h140
  };

  logic [7:0] v3 [12] = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h04, 8'h04, 8'h04,
                          8'h04, 8'h04, 8'h04, 8'h08};
  logic       e3v [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1};

  initial begin
    arst = 1'b1;
    en   = 1'b0;
    en3  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    arst = 1'b0;
    en   = 1'b1;
    q1.push_back(8'h01);
    q3.push_back(8'h01);

    // DIV=1: sweep, bounce, holds ascending at 08 and descending at 20.
    foreach (va[i]) cyc(va[i][8], 1'b0, va[i][7:0], 8'h00, 1'b0);

    // Async reset between edges while descending at 40.
    @(negedge clk);
    #1 arst = 1'b1;
    #1 chk("async_reset_div1", leds1, 8'h01);
    chk("async_reset_div3", leds3, 8'h01);
    #1 arst = 1'b0;
    cyc(1'b1, 1'b0, 8'h02, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h04, 8'h00, 1'b0);

    // DIV=3: step every third enabled edge; en low freezes the count.
    foreach (v3[i]) cyc(1'b0, e3v[i], 8'h04, v3[i], 1'b1);
    cyc(1'b0, 1'b1, 8'h04, 8'h08, 1'b1);
    cyc(1'b0, 1'b1, 8'h04, 8'h08, 1'b1);
    cyc(1'b0, 1'b1, 8'h04, 8'h10, 1'b1);

    for (int k = 0; k < 10 && (q1.size() > 0 || q3.size() > 0); k++) @(posedge clk);
    if (q1.size() > 0 || q3.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d/%0d expected values never checked", q1.size(), q3.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    checks++;
    failures++;
    $display("FAIL timeout: bench did not finish by %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
